// File: rtl/d_fifo_drain.sv
// Round-robin drain of D0/D1 FIFOs onto one valid/ready egress with dest tag and delivery counters.
// Latency: pop at t, word valid at t+2. out_valid holds the word until out_ready; no pop while stalled.
module d_fifo_drain #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_d0,
    input  logic                  empty_d1,
    input  logic [DATA_WIDTH-1:0] data_d0,
    input  logic [DATA_WIDTH-1:0] data_d1,
    output logic                  pop_d0,
    output logic                  pop_d1,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_dest,
    output logic [CNT_WIDTH-1:0]  count_d0,
    output logic [CNT_WIDTH-1:0]  count_d1,
    output logic                  idle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic   sel;
    logic   last_dest;
    logic   any_ne;
    logic   grant;
    logic   do_pop;
    logic   handshake;

    assign any_ne    = !empty_d0 || !empty_d1;
    // On a tie the FIFO that did not supply the previous word wins.
    assign grant     = (!empty_d0 && !empty_d1) ? ~last_dest : empty_d0;
    assign handshake = (state == OUT) && out_ready;
    assign idle      = (state == IDLE) && empty_d0 && empty_d1;

    always_comb begin
        state_nxt = state;
        do_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (any_ne) begin
                    do_pop    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    if (any_ne) begin
                        do_pop    = 1'b1;
                        state_nxt = READ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            do_pop = 1'b0;
        end
    end

    assign pop_d0 = do_pop && !grant;
    assign pop_d1 = do_pop && grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last_dest <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= 1'b0;
            count_d0  <= '0;
            count_d1  <= '0;
        end else begin
            state <= state_nxt;
            if (do_pop) begin
                sel <= grant;
            end
            if (state == READ) begin
                out_valid <= 1'b1;
                out_data  <= sel ? data_d1 : data_d0;
                out_dest  <= sel;
                last_dest <= sel;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                if (out_dest) begin
                    count_d1 <= count_d1 + CNT_ONE;
                end else begin
                    count_d0 <= count_d0 + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_d_fifo_drain.sv
// Bench for d_fifo_drain: queue-based FIFO/egress model plus per-scenario tasks.
module tb_d_fifo_drain;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       empty_d0 = 1'b1;
    logic       empty_d1 = 1'b1;
    logic [5:0] data_d0 = '0;
    logic [5:0] data_d1 = '0;
    logic       pop_d0, pop_d1;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [5:0] out_data;
    logic       out_dest;
    logic [4:0] count_d0, count_d1;
    logic       idle;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [6:0] expq[$];   // {dest, data} in expected egress order
    int         cnt0 = 0;
    int         cnt1 = 0;
    bit         last = 1'b1;

    d_fifo_drain dut (
        .clk(clk), .reset(reset), .empty_d0(empty_d0), .empty_d1(empty_d1),
        .data_d0(data_d0), .data_d1(data_d1), .pop_d0(pop_d0), .pop_d1(pop_d1),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_dest(out_dest), .count_d0(count_d0), .count_d1(count_d1), .idle(idle)
    );

    always #5 clk = ~clk;

    // FIFO and scoreboard model: sample at negedge, commit just after posedge.
    always begin : monitor
        bit r, p0, p1, hs, prev_pop, prev_stall;
        bit g;
        logic [5:0] prev_data;
        logic       prev_dest;
        logic [6:0] e;
        prev_pop = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_dest = 1'b0;
        forever begin
            @(negedge clk);
            r  = reset;
            p0 = pop_d0;
            p1 = pop_d1;
            hs = out_valid && out_ready;
            if (mon_en) begin
                checks++;
                if (count_d0 !== cnt0[4:0] || count_d1 !== cnt1[4:0]) begin
                    failures++;
                    $display("FAIL counters: got %0d/%0d expected %0d/%0d", count_d0, count_d1, cnt0[4:0], cnt1[4:0]);
                end
                checks++;
                if ((p0 && p1) || (p0 && q0.size() == 0) || (p1 && q1.size() == 0) || (r && (p0 || p1))) begin
                    failures++;
                    $display("FAIL pop_legal: pop_d0=%0b pop_d1=%0b sizes=%0d/%0d reset=%0b", p0, p1, q0.size(), q1.size(), r);
                end
                if (p0 || p1) begin
                    checks++;
                    if (prev_pop) begin
                        failures++;
                        $display("FAIL pop_consecutive: pop in two consecutive cycles");
                    end
                    g = (q0.size() != 0 && q1.size() != 0) ? !last : (q0.size() == 0);
                    checks++;
                    if (p1 !== g) begin
                        failures++;
                        $display("FAIL grant: got dest %0b expected %0b", p1, g);
                    end
                end
                if (!r && prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== prev_data || out_dest !== prev_dest) begin
                        failures++;
                        $display("FAIL stall_hold: valid=%0b data=%h dest=%0b expected 1/%h/%0b", out_valid, out_data, out_dest, prev_data, prev_dest);
                    end
                end
                if (!r && hs) begin
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL egress_unexpected: data=%h dest=%0b with nothing expected", out_data, out_dest);
                    end else if ({out_dest, out_data} !== expq[0]) begin
                        failures++;
                        $display("FAIL egress: got %0b/%h expected %0b/%h", out_dest, out_data, expq[0][6], expq[0][5:0]);
                    end
                end
            end
            prev_pop   = (p0 || p1) && !r;
            prev_stall = out_valid && !out_ready && !r;
            prev_data  = out_data;
            prev_dest  = out_dest;
            @(posedge clk);
            #1;
            if (r) begin
                expq.delete();
                cnt0 = 0;
                cnt1 = 0;
                last = 1'b1;
            end else begin
                if (hs && expq.size() != 0) begin
                    e = expq.pop_front();
                    if (e[6]) cnt1 = (cnt1 + 1) % 32;
                    else      cnt0 = (cnt0 + 1) % 32;
                end
                if (p0 && q0.size() != 0) begin
                    data_d0 = q0.pop_front();
                    expq.push_back({1'b0, data_d0});
                    last = 1'b0;
                end
                if (p1 && q1.size() != 0) begin
                    data_d1 = q1.pop_front();
                    expq.push_back({1'b1, data_d1});
                    last = 1'b1;
                end
            end
            empty_d0 = (q0.size() == 0);
            empty_d1 = (q1.size() == 0);
        end
    end

    task automatic push(input bit dest, input logic [5:0] w);
        if (dest) q1.push_back(w);
        else      q0.push_back(w);
        empty_d0 = (q0.size() == 0);
        empty_d1 = (q1.size() == 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        empty_d0 = 1'b1;
        empty_d1 = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(idle === 1'b1 && out_valid === 1'b0 && q0.size() == 0 && q1.size() == 0 && expq.size() == 0) && n < budget);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout: not idle after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        push(1'b0, 6'h11);
        push(1'b1, 6'h22);
        @(posedge clk); #2;
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (pop_d0 !== 1'b0 || pop_d1 !== 1'b0 || out_valid !== 1'b0 || count_d0 !== 5'd0 || count_d1 !== 5'd0 || out_data !== 6'd0 || out_dest !== 1'b0) begin
                failures++;
                $display("FAIL reset_values: pop=%0b%0b valid=%0b data=%h dest=%0b counts=%0d/%0d expected all zero", pop_d1, pop_d0, out_valid, out_data, out_dest, count_d0, count_d1);
            end
        end
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pop_d0 !== 1'b1 || pop_d1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_pop: pop_d0=%0b pop_d1=%0b expected 1/0", pop_d0, pop_d1);
        end
        wait_idle(50);
    endtask

    task automatic test_single_stream();
        logic [5:0] words [3];
        words[0] = 6'h05; words[1] = 6'h0A; words[2] = 6'h13;
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) push(1'b0, words[i]);
        @(negedge clk);
        checks++;
        if (pop_d0 !== 1'b1) begin
            failures++;
            $display("FAIL single_pop_t: pop_d0=%0b expected 1", pop_d0);
        end
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== words[i] || out_dest !== 1'b0) begin
                failures++;
                $display("FAIL single_word%0d: valid=%0b data=%h dest=%0b expected 1/%h/0", i, out_valid, out_data, out_dest, words[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (count_d0 !== 5'd3 || count_d1 !== 5'd0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL single_final: counts=%0d/%0d idle=%0b expected 3/0/1", count_d0, count_d1, idle);
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] order [4];
        int got = 0;
        int n = 0;
        order[0] = {1'b0, 6'h01}; order[1] = {1'b1, 6'h21};
        order[2] = {1'b0, 6'h02}; order[3] = {1'b1, 6'h22};
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #2;
        push(1'b0, 6'h01); push(1'b0, 6'h02);
        push(1'b1, 6'h21); push(1'b1, 6'h22);
        while (got < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid && out_ready) begin
                checks++;
                if ({out_dest, out_data} !== order[got]) begin
                    failures++;
                    $display("FAIL rr_order%0d: got %0b/%h expected %0b/%h", got, out_dest, out_data, order[got][6], order[got][5:0]);
                end
                got++;
            end
        end
        @(negedge clk);
        checks++;
        if (got != 4 || count_d0 !== 5'd2 || count_d1 !== 5'd2) begin
            failures++;
            $display("FAIL rr_final: words=%0d counts=%0d/%0d expected 4/2/2", got, count_d0, count_d1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        @(posedge clk); #2;
        push(1'b1, 6'h2C);
        @(posedge clk); #2;
        push(1'b0, 6'h07);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 6'h2C || out_dest !== 1'b1 || pop_d0 !== 1'b0 || pop_d1 !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall%0d: valid=%0b data=%h dest=%0b pops=%0b%0b expected 1/2c/1/00", i, out_valid, out_data, out_dest, pop_d1, pop_d0);
            end
        end
        @(posedge clk); #2 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (count_d1 !== 5'd1 || count_d0 !== 5'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: count_d1=%0d count_d0=%0d valid=%0b expected 1/0/0", count_d1, count_d0, out_valid);
        end
        wait_idle(50);
    endtask

    task automatic test_counter_wrap();
        do_reset();
        @(posedge clk); #2;
        for (int i = 0; i < 33; i++) push(1'b0, 6'($urandom_range(0, 63)));
        for (int i = 0; i < 300 && expq.size() + q0.size() != 0 || i < 2; i++) begin
            @(posedge clk); #2 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        wait_idle(100);
        checks++;
        if (count_d0 !== 5'd1 || count_d1 !== 5'd0) begin
            failures++;
            $display("FAIL wrap: counts=%0d/%0d expected 1/0", count_d0, count_d1);
        end
    endtask

    task automatic test_random_mix();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) push(1'b0, 6'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) push(1'b1, 6'($urandom_range(0, 63)));
        end
        @(posedge clk); #2 out_ready = 1'b1;
        wait_idle(400);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #2;
        push(1'b0, 6'h15);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || idle !== 1'b1 || count_d0 !== 5'd0 || count_d1 !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid: valid=%0b idle=%0b counts=%0d/%0d expected 0/1/0/0", out_valid, idle, count_d0, count_d1);
        end
        @(posedge clk); #2 reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_discard: valid=%0b idle=%0b expected 0/1", out_valid, idle);
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_counter_wrap();
        test_random_mix();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
